// File: rtl/acc_pkg.sv
// acc_pkg: shared types for the adaptive cruise controller.
//   state_t  - controller state, 3-bit encoding observable on state_o
//   STATE_W  - width of the state encoding
package acc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_STOP   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_CRUISE = 3'd2,
    ST_DECEL  = 3'd3,
    ST_EMERG  = 3'd4
  } state_t;

endpackage

// File: rtl/distance_filter.sv
// distance_filter: qualifies the "too close" condition so that braking only
// starts after FILTER_CYC consecutive close samples.
//   clk, rst          - clock, synchronous active-high reset
//   leading_distance  - distance to the car ahead
//   close             - raw, unfiltered close flag (combinational)
//   close_q           - close held for FILTER_CYC consecutive samples
module distance_filter #(
  parameter int DIST_W       = 7,
  parameter int MIN_DISTANCE = 40,
  parameter int FILTER_CYC   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] leading_distance,
  output logic              close,
  output logic              close_q
);

  localparam int CNT_W = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_CYC - 1);
  localparam logic [DIST_W:0]   MIN_D   = (DIST_W+1)'(MIN_DISTANCE);

  logic [CNT_W-1:0] close_cnt;

  assign close   = {1'b0, leading_distance} < MIN_D;
  // The current sample counts too, so close_q rises on the FILTER_CYC-th
  // consecutive close sample, not one after.
  assign close_q = close && (close_cnt >= CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst)
      close_cnt <= '0;
    else if (!close)
      close_cnt <= '0;            // any gap restarts the filter
    else if (close_cnt != CNT_MAX)
      close_cnt <= close_cnt + 1'b1;
  end

endmodule

// File: rtl/adaptive_cruise_ctrl.sv
// adaptive_cruise_ctrl: Moore FSM driving door lock, throttle, brake and
// emergency brake from speed and leading-distance sensors.
//   clk, rst          - clock, synchronous active-high reset
//   enable            - driver engages cruise
//   speed_limit       - target speed
//   car_speed         - measured speed
//   leading_distance  - distance to the car ahead
//   unlock_doors      - high in STOP
//   accelerate_car    - high in ACCEL
//   brake_car         - high in DECEL and EMERG
//   emergency_brake   - high in EMERG
//   state_o           - current state encoding
//   emerg_count       - saturating count of EMERG entries
module adaptive_cruise_ctrl
  import acc_pkg::*;
#(
  parameter int SPEED_W        = 8,
  parameter int DIST_W         = 7,
  parameter int MIN_DISTANCE   = 40,
  parameter int HYST           = 5,
  parameter int EMERG_DISTANCE = 10,
  parameter int SPEED_TOL      = 2,
  parameter int FILTER_CYC     = 3,
  parameter int EVT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed_limit,
  input  logic [SPEED_W-1:0] car_speed,
  input  logic [DIST_W-1:0]  leading_distance,
  output logic               unlock_doors,
  output logic               accelerate_car,
  output logic               brake_car,
  output logic               emergency_brake,
  output logic [STATE_W-1:0] state_o,
  output logic [EVT_W-1:0]   emerg_count
);

  // Far threshold; if it lies beyond the largest representable distance,
  // far can never be asserted.
  localparam int              FAR_I  = MIN_DISTANCE + HYST;
  localparam bit              FAR_OK = FAR_I <= ((1 << DIST_W) - 1);
  localparam logic [DIST_W:0] FAR_TH = (DIST_W+1)'(FAR_I);
  localparam logic [DIST_W:0] EMG_TH = (DIST_W+1)'(EMERG_DISTANCE);
  localparam logic [SPEED_W:0] TOL   = (SPEED_W+1)'(SPEED_TOL);

  state_t state, next_state;

  logic             close, close_q, far, emerg;
  logic [SPEED_W:0] spd_x, lim_x, lo;
  logic             at_band, hi_gap, below_lim, over_lim, stopped;

  distance_filter #(
    .DIST_W       (DIST_W),
    .MIN_DISTANCE (MIN_DISTANCE),
    .FILTER_CYC   (FILTER_CYC)
  ) u_filt (
    .clk              (clk),
    .rst              (rst),
    .leading_distance (leading_distance),
    .close            (close),
    .close_q          (close_q)
  );

  assign far   = FAR_OK && ({1'b0, leading_distance} >= FAR_TH);
  assign emerg = {1'b0, leading_distance} < EMG_TH;

  // Speed compares in SPEED_W+1 bits so the tolerance add cannot wrap.
  assign spd_x     = {1'b0, car_speed};
  assign lim_x     = {1'b0, speed_limit};
  assign lo        = (lim_x >= TOL) ? (lim_x - TOL) : '0;
  assign at_band   = spd_x >= lo;
  assign hi_gap    = (spd_x + TOL) < lim_x;
  assign below_lim = car_speed < speed_limit;
  assign over_lim  = car_speed > speed_limit;
  assign stopped   = car_speed == '0;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_STOP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_STOP:
        if (enable && far && !emerg && below_lim) next_state = ST_ACCEL;
      ST_ACCEL:
        if (emerg)                                next_state = ST_EMERG;
        else if (!enable || close_q || over_lim)  next_state = ST_DECEL;
        else if (at_band)                         next_state = ST_CRUISE;
      ST_CRUISE:
        if (emerg)                                next_state = ST_EMERG;
        else if (!enable || close_q || over_lim)  next_state = ST_DECEL;
        else if (far && hi_gap)                   next_state = ST_ACCEL;
      ST_DECEL:
        if (emerg)                                next_state = ST_EMERG;
        else if (stopped)                         next_state = ST_STOP;
        else if (enable && far && below_lim)      next_state = ST_ACCEL;
      // EMERG is latched until the car has stopped.
      ST_EMERG:
        if (stopped)                              next_state = ST_STOP;
      default:                                    next_state = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      emerg_count <= '0;
    else if (next_state == ST_EMERG && state != ST_EMERG && emerg_count != '1)
      emerg_count <= emerg_count + 1'b1;
  end

  always_comb begin
    unlock_doors    = state == ST_STOP;
    accelerate_car  = state == ST_ACCEL;
    brake_car       = (state == ST_DECEL) || (state == ST_EMERG);
    emergency_brake = state == ST_EMERG;
    state_o         = state;
  end

endmodule

// File: tb/tb_adaptive_cruise_ctrl.sv
// Directed bench for adaptive_cruise_ctrl, built with EVT_W=2 so the
// emergency counter saturation is reachable in a few cycles.
module tb_adaptive_cruise_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [7:0] speed_limit, car_speed;
  logic [6:0] leading_distance;
  logic       unlock_doors, accelerate_car, brake_car, emergency_brake;
  logic [2:0] state_o;
  logic [1:0] emerg_count;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] S_STOP = 3'd0, S_ACCEL = 3'd1, S_CRUISE = 3'd2,
                         S_DECEL = 3'd3, S_EMERG = 3'd4;

  always #5 clk = ~clk;

  adaptive_cruise_ctrl #(
    .SPEED_W(8), .DIST_W(7), .MIN_DISTANCE(40), .HYST(5),
    .EMERG_DISTANCE(10), .SPEED_TOL(2), .FILTER_CYC(3), .EVT_W(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .speed_limit      (speed_limit),
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .unlock_doors     (unlock_doors),
    .accelerate_car   (accelerate_car),
    .brake_car        (brake_car),
    .emergency_brake  (emergency_brake),
    .state_o          (state_o),
    .emerg_count      (emerg_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Step one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {unlock, accel, brake, ebrake, state} hand-tabulated per state.
  function automatic logic [6:0] outs_for(input logic [2:0] s);
    case (s)
      S_STOP:   return {4'b1000, s};
      S_ACCEL:  return {4'b0100, s};
      S_CRUISE: return {4'b0000, s};
      S_DECEL:  return {4'b0010, s};
      S_EMERG:  return {4'b0011, s};
      default:  return 7'h7f;
    endcase
  endfunction

  task automatic chk_st(input string tag, input logic [2:0] s);
    chk(tag, {unlock_doors, accelerate_car, brake_car, emergency_brake, state_o},
        outs_for(s));
  endtask

  task automatic drive(input logic en, input logic [7:0] lim,
                       input logic [7:0] spd, input logic [6:0] d);
    enable = en; speed_limit = lim; car_speed = spd; leading_distance = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'd100, 8'd0, 7'd45);
    #1;
    tick();
    // 1. reset
    chk_st("reset_outs", S_STOP);
    chk("reset_cnt", emerg_count, 2'd0);
    rst = 1'b0;

    // Boundary: speed_limit 0 never allows ACCEL
    drive(1'b1, 8'd0, 8'd0, 7'd45);
    tick(); chk_st("lim0_stop", S_STOP);
    tick(); chk_st("lim0_stop2", S_STOP);

    // 2. accelerate to cruise
    drive(1'b1, 8'd100, 8'd0, 7'd45);
    tick(); chk_st("stop_to_accel", S_ACCEL);
    car_speed = 8'd98;
    tick(); chk_st("accel_to_cruise", S_CRUISE);
    car_speed = 8'd97;
    tick(); chk_st("cruise_to_accel", S_ACCEL);
    car_speed = 8'd98;
    tick(); chk_st("back_to_cruise", S_CRUISE);

    // 3. filter: DECEL only on 3rd consecutive close sample
    leading_distance = 7'd30;
    tick(); chk_st("filt_edge1", S_CRUISE);
    tick(); chk_st("filt_edge2", S_CRUISE);
    tick(); chk_st("filt_edge3", S_DECEL);
    leading_distance = 7'd45;
    tick(); chk_st("decel_to_accel", S_ACCEL);
    tick(); chk_st("accel_to_cruise2", S_CRUISE);
    for (int i = 0; i < 6; i++) begin
      leading_distance = (i % 2 == 0) ? 7'd30 : 7'd45;
      tick(); chk_st($sformatf("alt_%0d", i), S_CRUISE);
    end
    // Filter restart: two close, one gap, two close still no brake
    leading_distance = 7'd30; tick(); tick();
    leading_distance = 7'd42; tick(); chk_st("gap_hold", S_CRUISE);
    leading_distance = 7'd30; tick(); tick(); chk_st("restart_2", S_CRUISE);
    tick(); chk_st("restart_3", S_DECEL);

    // 4. hysteresis: 42 is neither close nor far, hold DECEL
    drive(1'b1, 8'd100, 8'd50, 7'd42);
    tick(); chk_st("hyst_hold1", S_DECEL);
    tick(); chk_st("hyst_hold2", S_DECEL);
    leading_distance = 7'd44;
    tick(); chk_st("hyst_44", S_DECEL);
    leading_distance = 7'd45;
    tick(); chk_st("hyst_far", S_ACCEL);

    // 5. emergency from ACCEL, latched
    leading_distance = 7'd5;
    tick(); chk_st("emerg_entry", S_EMERG);
    chk("emerg_cnt1", emerg_count, 2'd1);
    leading_distance = 7'd60; enable = 1'b0;
    tick(); chk_st("emerg_latched", S_EMERG);
    chk("emerg_cnt_hold", emerg_count, 2'd1);
    car_speed = 8'd0;
    tick(); chk_st("emerg_to_stop", S_STOP);

    // 6. three more emergencies, counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'd100, 8'd0, 7'd45);
      tick(); chk_st($sformatf("ecyc%0d_accel", k), S_ACCEL);
      leading_distance = 7'd5;
      tick(); chk_st($sformatf("ecyc%0d_emerg", k), S_EMERG);
      chk($sformatf("ecyc%0d_cnt", k), emerg_count, (k == 0) ? 2'd2 : 2'd3);
      tick(); chk_st($sformatf("ecyc%0d_stop", k), S_STOP);
    end

    // reset mid-run from ACCEL
    drive(1'b1, 8'd100, 8'd20, 7'd45);
    tick(); chk_st("pre_rst_accel", S_ACCEL);
    rst = 1'b1;
    tick(); chk_st("rst_mid_stop", S_STOP);
    chk("rst_mid_cnt", emerg_count, 2'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
